instr_prefetch_queue: RTL and testbench

- Fetch-side buffer between the instruction memory and the IF/ID pipeline register.
- Issues sequential instruction fetches over a req/ack memory interface that may take several cycles.
- Queues up to DEPTH fetched {PC, instruction} pairs and presents the oldest to IF/ID.
- Discards all queued and in-flight work when the decode stage redirects the PC (taken branch or exception).

---
 rtl/instr_prefetch_queue_pkg.sv | 21 ++
 rtl/instr_prefetch_queue_fifo.sv | 61 ++++++
 rtl/instr_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
// Contents: fetch state encoding, queue entry layout ({pc, instr}),
// the NOP word, the exception vector and the default reset PC.
package instr_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no request outstanding (queue full or waiting for space)
        REQ  = 2'd1,  // request at fetchAddr outstanding; its data is kept
        DROP = 2'd2   // stale request outstanding after a redirect; its data is discarded
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR       = 32'h0000_0100;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write pushData at the tail (ignored when full)
//   pushData  : entry to write
//   pop       : drop the head entry (ignored when empty)
//   clear     : empty the FIFO; wins over push and pop in the same cycle
//   count     : number of valid entries
//   head      : oldest entry, combinational (undefined when count == 0)
module fetch_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  fetch_entry_t                 pushData,
    input  logic                         pop,
    input  logic                         clear,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output fetch_entry_t                 head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rdPtr;
    logic [AW-1:0]  wrPtr;
    logic           doPush;
    logic           doPop;

    assign doPush = push & (count != CW'(DEPTH)) & ~clear;
    assign doPop  = pop & (count != '0) & ~clear;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    // Storage carries no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign head = mem[rdPtr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch-side buffer between instruction memory and IF/ID.
// Issues sequential fetches (one outstanding), queues up to DEPTH {pc, instr}
// pairs and presents the oldest one. A Redirect flushes the queue and any
// in-flight fetch, then fetching restarts at RedirectPC.
//
// Handshakes:
//   Memory side: ImemReq stays high with ImemAddr stable until a cycle with
//   ImemAck=1; that cycle completes the fetch and ImemData is sampled. ImemAck
//   while ImemReq=0 is ignored.
//   Consumer side: the head entry is popped at the clock edge of any cycle with
//   InstrValid=1 and IF_ID_Write=1 (unless Redirect is also high).
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   Redirect       : flush queue and refetch from RedirectPC
//   RedirectPC     : new fetch address
//   IF_ID_Write    : consumer ready
//   InstrValid     : head entry valid
//   Instruction    : head instruction, NOP when empty
//   FetchPC        : head PC (0 when empty)
//   PCadderResult  : FetchPC + 4
//   ImemReq/ImemAddr/ImemAck/ImemData : memory fetch interface
//   Count          : number of valid queue entries
//   FetchState     : current fetch state, for observation
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        Redirect,
    input  logic [31:0]                 RedirectPC,
    input  logic                        IF_ID_Write,
    output logic                        InstrValid,
    output logic [31:0]                 Instruction,
    output logic [31:0]                 FetchPC,
    output logic [31:0]                 PCadderResult,
    output logic                        ImemReq,
    output logic [31:0]                 ImemAddr,
    input  logic                        ImemAck,
    input  logic [31:0]                 ImemData,
    output logic [$clog2(DEPTH+1)-1:0]  Count,
    output fetch_state_e                FetchState
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e   state;
    logic [31:0]    fetchAddr;
    logic [31:0]    dropAddr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  countNext;
    fetch_entry_t   head;
    fetch_entry_t   pushEntry;
    logic           pushEn;
    logic           popEn;
    logic           space;

    // Redirect overrides both queue operations; the FIFO clear does the rest.
    assign popEn     = InstrValid & IF_ID_Write & ~Redirect;
    assign pushEn    = (state == REQ) & ImemAck & ~Redirect;
    assign pushEntry = '{pc: fetchAddr, instr: ImemData};

    // Occupancy after this cycle's push/pop; a new request is only issued
    // when that leaves room, so the FIFO is never pushed while full.
    assign countNext = count + CW'(pushEn) - CW'(popEn);
    assign space     = countNext < CW'(DEPTH);

    fetch_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushEn),
        .pushData (pushEntry),
        .pop      (popEn),
        .clear    (Redirect),
        .count    (count),
        .head     (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetchAddr <= RESET_PC;
            dropAddr  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (Redirect) begin
                        fetchAddr <= RedirectPC;
                        state     <= REQ;
                    end else if (space) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (Redirect) begin
                        fetchAddr <= RedirectPC;
                        // An ack in the same cycle completes the old fetch, so
                        // only an unfinished one needs to be held and drained.
                        if (!ImemAck) begin
                            dropAddr <= fetchAddr;
                            state    <= DROP;
                        end
                    end else if (ImemAck) begin
                        fetchAddr <= fetchAddr + 32'd4;
                        state     <= space ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (Redirect) fetchAddr <= RedirectPC;
                    if (ImemAck)  state     <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ImemReq       = (state != IDLE);
    assign ImemAddr      = (state == DROP) ? dropAddr : fetchAddr;
    assign InstrValid    = (count != '0);
    assign Instruction   = InstrValid ? head.instr : NOP_INSTR;
    assign FetchPC       = InstrValid ? head.pc : 32'h0000_0000;
    assign PCadderResult = FetchPC + 32'd4;
    assign Count         = count;
    assign FetchState    = state;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic          redirect = 1'b0;
    logic [31:0]   redirectPc = 32'h0;
    logic          ifIdWrite = 1'b0;
    logic          instrValid;
    logic [31:0]   instruction;
    logic [31:0]   fetchPc;
    logic [31:0]   pcAdderResult;
    logic          imemReq;
    logic [31:0]   imemAddr;
    logic          imemAck = 1'b0;
    logic [31:0]   imemData = 32'h0;
    logic [2:0]    count;
    fetch_state_e  fetchState;

    // second DUT to exercise address wrap from a high RESET_PC
    logic          wIfIdWrite = 1'b0;
    logic          wInstrValid;
    logic [31:0]   wInstruction;
    logic [31:0]   wFetchPc;
    logic [31:0]   wPcAdderResult;
    logic          wImemReq;
    logic [31:0]   wImemAddr;
    logic          wImemAck = 1'b0;
    logic [31:0]   wImemData = 32'h0;
    logic [2:0]    wCount;
    fetch_state_e  wFetchState;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .Redirect(redirect), .RedirectPC(redirectPc),
        .IF_ID_Write(ifIdWrite), .InstrValid(instrValid), .Instruction(instruction),
        .FetchPC(fetchPc), .PCadderResult(pcAdderResult), .ImemReq(imemReq),
        .ImemAddr(imemAddr), .ImemAck(imemAck), .ImemData(imemData),
        .Count(count), .FetchState(fetchState)
    );

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dutWrap (
        .clk(clk), .rst(rst), .Redirect(1'b0), .RedirectPC(32'h0),
        .IF_ID_Write(wIfIdWrite), .InstrValid(wInstrValid), .Instruction(wInstruction),
        .FetchPC(wFetchPc), .PCadderResult(wPcAdderResult), .ImemReq(wImemReq),
        .ImemAddr(wImemAddr), .ImemAck(wImemAck), .ImemData(wImemData),
        .Count(wCount), .FetchState(wFetchState)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    // Memory contents: a fixed, address-unique, non-NOP word per address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Asserts reset between edges and checks the reset values before any
    // clock edge arrives, then releases it on a falling edge.
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0;
        imemAck = 1'b0;
        ifIdWrite = 1'b0;
        wImemAck = 1'b0;
        wIfIdWrite = 1'b0;
        #1;
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_addr", imemAddr, 32'h0);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_instr", instruction, NOP_INSTR);
        check("rst_fetchpc", fetchPc, 32'h0);
        check("rst_pcadder", pcAdderResult, 32'd4);
        check("rst_count", 32'(count), 32'd0);
        check("rst_state", 32'(fetchState), 32'(IDLE));
        check("rst_wrap_addr", wImemAddr, WRAP_PC);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // 3-cycle-latency memory: ack on the third cycle a request is seen.
    int waitCnt = 0;
    task automatic memLatencyStep();
        if (!imemReq) begin
            waitCnt = 0;
            imemAck = 1'b0;
        end else begin
            waitCnt++;
            if (waitCnt >= 3) begin
                imemAck = 1'b1;
                imemData = memWord(imemAddr);
                waitCnt = 0;
            end else begin
                imemAck = 1'b0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic        ack;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
        logic [2:0]  expCount;
    } vec_t;

    function automatic vec_t mkVec(input logic wr, input logic ack, input logic req,
                                   input logic [31:0] addr, input logic valid,
                                   input logic [31:0] pc, input logic [2:0] cnt);
        vec_t v;
        v.wr = wr; v.ack = ack; v.expReq = req; v.expAddr = addr;
        v.expValid = valid; v.expPc = pc; v.expCount = cnt;
        return v;
    endfunction

    vec_t vecs[14];
    int guard;
    logic [31:0] e;
    logic [31:0] expPc;
    logic [31:0] prevAddr;
    logic prevHold;
    int pops;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Outputs observed on the falling edge, then inputs applied for the
        // next rising edge. Rows start right after reset release.
        vecs[0]  = mkVec(1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0,  3'd0);
        vecs[1]  = mkVec(1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0,  3'd0);
        vecs[2]  = mkVec(1'b1, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0,  3'd1);
        vecs[3]  = mkVec(1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4,  3'd1);
        vecs[4]  = mkVec(1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4,  3'd2);
        vecs[5]  = mkVec(1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd4,  3'd3);
        vecs[6]  = mkVec(1'b0, 1'b1, 1'b0, 32'd20, 1'b1, 32'd4,  3'd4);
        vecs[7]  = mkVec(1'b1, 1'b1, 1'b0, 32'd20, 1'b1, 32'd4,  3'd4);
        vecs[8]  = mkVec(1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8,  3'd3);
        vecs[9]  = mkVec(1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 32'd12, 3'd3);
        vecs[10] = mkVec(1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 32'd16, 3'd2);
        vecs[11] = mkVec(1'b1, 1'b0, 1'b1, 32'd24, 1'b1, 32'd20, 3'd1);
        vecs[12] = mkVec(1'b1, 1'b1, 1'b1, 32'd24, 1'b0, 32'd0,  3'd0);
        vecs[13] = mkVec(1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd24, 3'd1);

        // ---- table-driven streaming / backpressure ----
        doReset();
        for (int i = 0; i < 14; i++) begin
            check($sformatf("vec%0d_req", i), 32'(imemReq), 32'(vecs[i].expReq));
            check($sformatf("vec%0d_addr", i), imemAddr, vecs[i].expAddr);
            check($sformatf("vec%0d_valid", i), 32'(instrValid), 32'(vecs[i].expValid));
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].expCount));
            check($sformatf("vec%0d_instr", i), instruction,
                  vecs[i].expValid ? memWord(vecs[i].expPc) : NOP_INSTR);
            if (i == 0 || vecs[i].expValid) begin
                check($sformatf("vec%0d_fetchpc", i), fetchPc, vecs[i].expPc);
                check($sformatf("vec%0d_pcadder", i), pcAdderResult, vecs[i].expPc + 32'd4);
            end
            ifIdWrite = vecs[i].wr;
            imemAck = vecs[i].ack;
            imemData = memWord(imemAddr);
            @(negedge clk);
        end

        // ---- redirect during a 3-cycle fetch ----
        doReset();
        ifIdWrite = 1'b1;
        waitCnt = 0;
        guard = 0;
        while (!(imemReq && imemAddr == 32'd8) && guard < 50) begin
            memLatencyStep();
            @(negedge clk);
            guard++;
        end
        check("lat_reached_fetch8", 32'(guard < 50), 32'd1);
        memLatencyStep();               // first wait cycle of fetch at 8
        @(negedge clk);
        memLatencyStep();               // second wait cycle
        redirect = 1'b1;
        redirectPc = 32'h40;
        @(negedge clk);
        redirect = 1'b0;
        check("lat_drop_req", 32'(imemReq), 32'd1);
        check("lat_drop_addr_held", imemAddr, 32'd8);
        check("lat_drop_count", 32'(count), 32'd0);
        check("lat_drop_valid", 32'(instrValid), 32'd0);
        memLatencyStep();               // ack of the stale fetch
        @(negedge clk);
        check("lat_next_addr", imemAddr, 32'h40);
        check("lat_stale_not_queued", 32'(instrValid), 32'd0);
        guard = 0;
        while (!instrValid && guard < 20) begin
            memLatencyStep();
            @(negedge clk);
            guard++;
        end
        check("lat_valid_seen", 32'(instrValid), 32'd1);
        check("lat_first_pc", fetchPc, 32'h40);
        check("lat_first_instr", instruction, memWord(32'h40));
        imemAck = 1'b0;

        // ---- redirect and ack in the same cycle, 2 entries queued ----
        doReset();
        imemAck = 1'b1;
        guard = 0;
        while (count != 3'd2 && guard < 20) begin
            imemData = memWord(imemAddr);
            @(negedge clk);
            guard++;
        end
        check("same_two_entries", 32'(count), 32'd2);
        redirect = 1'b1;
        redirectPc = 32'h200;
        imemData = memWord(imemAddr);
        @(negedge clk);
        redirect = 1'b0;
        imemAck = 1'b0;
        check("same_count", 32'(count), 32'd0);
        check("same_valid", 32'(instrValid), 32'd0);
        check("same_instr_nop", instruction, NOP_INSTR);
        check("same_addr", imemAddr, 32'h200);
        check("same_req", 32'(imemReq), 32'd1);
        imemAck = 1'b1;
        imemData = memWord(imemAddr);
        @(negedge clk);
        imemAck = 1'b0;
        check("same_next_pc", fetchPc, 32'h200);
        check("same_next_instr", instruction, memWord(32'h200));

        // ---- fill to full, drain in order, refill, exception redirect ----
        doReset();
        imemAck = 1'b1;
        guard = 0;
        while (count != 3'd4 && guard < 20) begin
            imemData = memWord(imemAddr);
            @(negedge clk);
            guard++;
        end
        check("full_count", 32'(count), 32'd4);
        check("full_req_low", 32'(imemReq), 32'd0);
        exp_q = '{32'd0, 32'd4, 32'd8, 32'd12};
        ifIdWrite = 1'b1;
        imemAck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            check($sformatf("drain%0d_valid", i), 32'(instrValid), 32'd1);
            check($sformatf("drain%0d_pc", i), fetchPc, e);
            if (i == 1) begin
                check("drain_resume_req", 32'(imemReq), 32'd1);
                check("drain_resume_addr", imemAddr, 32'd16);
            end
            @(negedge clk);
        end
        ifIdWrite = 1'b0;
        imemAck = 1'b1;
        guard = 0;
        while (count != 3'd4 && guard < 20) begin
            imemData = memWord(imemAddr);
            @(negedge clk);
            guard++;
        end
        check("refill_count", 32'(count), 32'd4);
        check("refill_head", fetchPc, 32'd16);
        redirect = 1'b1;
        redirectPc = EXC_VECTOR;
        ifIdWrite = 1'b1;
        imemAck = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        check("exc_count", 32'(count), 32'd0);
        check("exc_valid", 32'(instrValid), 32'd0);
        check("exc_addr", imemAddr, EXC_VECTOR);
        imemAck = 1'b1;
        imemData = memWord(imemAddr);
        @(negedge clk);
        imemAck = 1'b0;
        check("exc_first_valid", 32'(instrValid), 32'd1);
        check("exc_first_pc", fetchPc, EXC_VECTOR);
        check("exc_first_pcadder", pcAdderResult, EXC_VECTOR + 32'd4);

        // ---- address wrap from RESET_PC = FFFF_FFF8 ----
        doReset();
        wIfIdWrite = 1'b1;
        wImemAck = 1'b1;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            wImemData = memWord(wImemAddr);
            if (wInstrValid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wrap_pc", wFetchPc, e);
                check("wrap_pcadder", wPcAdderResult, e + 32'd4);
                check("wrap_instr", wInstruction, memWord(e));
            end
            @(negedge clk);
        end
        check("wrap_all_seen", 32'(exp_q.size()), 32'd0);
        wImemAck = 1'b0;
        wIfIdWrite = 1'b0;

        // ---- randomized run against a stream-level model ----
        // Model: the consumer sees consecutive words PC, PC+4, ... starting at
        // the reset PC or the latest redirect target, each equal to memWord(PC).
        doReset();
        expPc = 32'h0;
        prevHold = 1'b0;
        prevAddr = 32'h0;
        pops = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (prevHold) begin
                check("rnd_req_held", 32'(imemReq), 32'd1);
                check("rnd_addr_held", imemAddr, prevAddr);
            end
            check("rnd_count_bound", 32'(count <= 3'(DEPTH)), 32'd1);
            if (!instrValid) check("rnd_nop", instruction, NOP_INSTR);

            ifIdWrite = ($urandom_range(0, 3) != 0);
            imemAck = 1'($urandom_range(0, 1));
            imemData = memWord(imemAddr);
            redirect = ($urandom_range(0, 31) == 0);
            redirectPc = ($urandom_range(0, 3) == 0) ? EXC_VECTOR : ($urandom & 32'hFFFF_FFFC);

            if (redirect) begin
                expPc = redirectPc;
            end else if (instrValid && ifIdWrite) begin
                check("rnd_pop_pc", fetchPc, expPc);
                check("rnd_pop_instr", instruction, memWord(expPc));
                check("rnd_pop_pcadder", pcAdderResult, expPc + 32'd4);
                expPc = expPc + 32'd4;
                pops++;
            end
            prevHold = imemReq && !imemAck;
            prevAddr = imemAddr;
            @(negedge clk);
        end
        check("rnd_progress", 32'(pops > 100), 32'd1);
        redirect = 1'b0;
        imemAck = 1'b0;
        ifIdWrite = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
